// File: rtl/dcache_nway.sv
// dcache_nway: N-way set-associative, write-back, write-allocate data cache.
//
// Ports:
//   clk_i, rst_ni          clock (rising edge), asynchronous active-low reset
//   req_*_i / req_ready_o  CPU request: valid/ready, write flag, byte address, data, byte mask
//   resp_valid_o           one-cycle completion pulse; read_data_o holds load data (0 for stores)
//   flush_req_i            start flush-all (only sampled while req_ready_o=1)
//   flush_busy_o/done_o    flush in progress / one-cycle completion pulse
//   mem_req_*              line-wide memory request (writeback or fetch), held until ready
//   mem_resp_valid_i       fetched line valid (one-cycle pulse), data on mem_read_data_i
module dcache_nway #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_BYTES = 32,
    parameter int unsigned SETS       = 512,
    parameter int unsigned WAYS       = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_write_i,
    input  logic [ADDR_WIDTH-1:0]   address_i,
    input  logic [31:0]             write_data_i,
    input  logic [3:0]              write_mask_i,
    output logic                    resp_valid_o,
    output logic [31:0]             read_data_o,
    input  logic                    flush_req_i,
    output logic                    flush_busy_o,
    output logic                    flush_done_o,
    output logic                    mem_req_valid_o,
    input  logic                    mem_req_ready_i,
    output logic                    mem_req_write_o,
    output logic [ADDR_WIDTH-1:0]   mem_address_o,
    output logic [8*LINE_BYTES-1:0] mem_write_data_o,
    input  logic                    mem_resp_valid_i,
    input  logic [8*LINE_BYTES-1:0] mem_read_data_i
);

    localparam int unsigned OFF  = $clog2(LINE_BYTES);
    localparam int unsigned IDX  = $clog2(SETS);
    localparam int unsigned TAG  = ADDR_WIDTH - IDX - OFF;
    localparam int unsigned LW   = 8 * LINE_BYTES;
    localparam int unsigned WB   = $clog2(WAYS);
    localparam int unsigned WPL  = LINE_BYTES / 4;
    localparam int unsigned WSEL = OFF - 2;

    typedef enum logic [2:0] {
        StIdle, StWb, StFillReq, StFillWait, StResp, StFlScan, StFlWb
    } state_e;

    // Tag/data arrays carry no reset; valid/dirty/pLRU do.
    logic [TAG-1:0]  tag_q   [SETS][WAYS];
    logic [LW-1:0]   data_q  [SETS][WAYS];
    logic [WAYS-1:0] valid_q [SETS];
    logic [WAYS-1:0] dirty_q [SETS];
    logic [WAYS-2:0] plru_q  [SETS];

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wmask_q, wmask_d;
    logic                  write_q, write_d;
    logic [WB-1:0]         way_q, way_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [IDX-1:0]        fset_q, fset_d;
    logic [WB-1:0]         fway_q, fway_d;
    logic                  done_q, done_d;

    // Pseudo-LRU tree, heap order with root at node 0; a node bit points toward the victim
    // (0 = lower half, 1 = upper half).
    function automatic logic [WB-1:0] plru_victim(input logic [WAYS-2:0] t);
        int node;
        int way;
        node = 0;
        way  = 0;
        for (int l = 0; l < int'(WB); l++) begin
            if (t[node[WB-1:0]]) begin
                way  = 2 * way + 1;
                node = 2 * node + 2;
            end else begin
                way  = 2 * way;
                node = 2 * node + 1;
            end
        end
        return way[WB-1:0];
    endfunction

    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] t,
                                                   input logic [WB-1:0]   w);
        logic [WAYS-2:0] r;
        int node;
        int wi;
        int b;
        r    = t;
        node = 0;
        wi   = int'(32'(w));
        for (int l = 0; l < int'(WB); l++) begin
            b = (wi >> (int'(WB) - 1 - l)) & 1;
            r[node[WB-1:0]] = (b == 0);
            node = 2 * node + 1 + b;
        end
        return r;
    endfunction

    function automatic logic [31:0] word_of(input logic [LW-1:0] line, input logic [WSEL-1:0] sel);
        logic [31:0] r;
        r = '0;
        for (int w = 0; w < int'(WPL); w++) begin
            if (sel == WSEL'(w)) r = line[w*32 +: 32];
        end
        return r;
    endfunction

    function automatic logic [LW-1:0] merge_word(input logic [LW-1:0]   line,
                                                 input logic [WSEL-1:0] sel,
                                                 input logic [31:0]     data,
                                                 input logic [3:0]      mask);
        logic [LW-1:0] r;
        r = line;
        for (int w = 0; w < int'(WPL); w++) begin
            for (int b = 0; b < 4; b++) begin
                if (sel == WSEL'(w) && mask[b]) r[w*32 + b*8 +: 8] = data[b*8 +: 8];
            end
        end
        return r;
    endfunction

    // In IDLE the live request is decoded; elsewhere the latched one.
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [IDX-1:0]        cur_idx;
    logic [TAG-1:0]        cur_tag;
    logic [WSEL-1:0]       cur_word;
    logic                  unused_addr_lo;

    assign cur_addr       = (state_q == StIdle) ? address_i : addr_q;
    assign cur_idx        = cur_addr[OFF+IDX-1:OFF];
    assign cur_tag        = cur_addr[ADDR_WIDTH-1:OFF+IDX];
    assign cur_word       = cur_addr[OFF-1:2];
    assign unused_addr_lo = ^cur_addr[1:0];

    logic          hit, inv;
    logic [WB-1:0] hit_way, inv_way, vic_way;
    logic [LW-1:0] hit_line;

    // Descending scan leaves the lowest-numbered match.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        inv     = 1'b0;
        inv_way = '0;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (valid_q[cur_idx][w] && tag_q[cur_idx][w] == cur_tag) begin
                hit     = 1'b1;
                hit_way = WB'(w);
            end
            if (!valid_q[cur_idx][w]) begin
                inv     = 1'b1;
                inv_way = WB'(w);
            end
        end
    end

    assign vic_way  = inv ? inv_way : plru_victim(plru_q[cur_idx]);
    assign hit_line = data_q[cur_idx][hit_way];

    logic          fl_last;
    assign fl_last = (fset_q == IDX'(SETS - 1)) && (fway_q == WB'(WAYS - 1));

    logic          we_line, wdirty, dclr, plru_we;
    logic [WB-1:0] ww;
    logic [LW-1:0] wline;

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        wmask_d          = wmask_q;
        write_d          = write_q;
        way_d            = way_q;
        rdata_d          = rdata_q;
        fset_d           = fset_q;
        fway_d           = fway_q;
        done_d           = 1'b0;
        we_line          = 1'b0;
        wdirty           = 1'b0;
        dclr             = 1'b0;
        plru_we          = 1'b0;
        ww               = way_q;
        wline            = '0;
        req_ready_o      = 1'b0;
        resp_valid_o     = 1'b0;
        read_data_o      = '0;
        mem_req_valid_o  = 1'b0;
        mem_req_write_o  = 1'b0;
        mem_address_o    = '0;
        mem_write_data_o = '0;

        unique case (state_q)
            StIdle: begin
                req_ready_o = 1'b1;
                if (flush_req_i) begin
                    fset_d  = '0;
                    fway_d  = '0;
                    state_d = StFlScan;
                end else if (req_valid_i) begin
                    addr_d  = address_i;
                    wdata_d = write_data_i;
                    wmask_d = write_mask_i;
                    write_d = req_write_i;
                    if (hit) begin
                        ww      = hit_way;
                        plru_we = 1'b1;
                        rdata_d = req_write_i ? 32'h0 : word_of(hit_line, cur_word);
                        if (req_write_i) begin
                            we_line = 1'b1;
                            wdirty  = 1'b1;
                            wline   = merge_word(hit_line, cur_word, write_data_i, write_mask_i);
                        end
                        state_d = StResp;
                    end else begin
                        way_d   = vic_way;
                        state_d = dirty_q[cur_idx][vic_way] ? StWb : StFillReq;
                    end
                end
            end
            StWb: begin
                mem_req_valid_o  = 1'b1;
                mem_req_write_o  = 1'b1;
                mem_address_o    = {tag_q[cur_idx][way_q], cur_idx, {OFF{1'b0}}};
                mem_write_data_o = data_q[cur_idx][way_q];
                if (mem_req_ready_i) state_d = StFillReq;
            end
            StFillReq: begin
                mem_req_valid_o = 1'b1;
                mem_address_o   = {addr_q[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
                if (mem_req_ready_i) state_d = StFillWait;
            end
            StFillWait: begin
                if (mem_resp_valid_i) begin
                    we_line = 1'b1;
                    plru_we = 1'b1;
                    wdirty  = write_q;
                    wline   = write_q ? merge_word(mem_read_data_i, cur_word, wdata_q, wmask_q)
                                      : mem_read_data_i;
                    rdata_d = write_q ? 32'h0 : word_of(mem_read_data_i, cur_word);
                    state_d = StResp;
                end
            end
            StResp: begin
                resp_valid_o = 1'b1;
                read_data_o  = rdata_q;
                state_d      = StIdle;
            end
            StFlScan, StFlWb: begin
                if (state_q == StFlWb) begin
                    mem_req_valid_o  = 1'b1;
                    mem_req_write_o  = 1'b1;
                    mem_address_o    = {tag_q[fset_q][fway_q], fset_q, {OFF{1'b0}}};
                    mem_write_data_o = data_q[fset_q][fway_q];
                end
                if (state_q == StFlScan && dirty_q[fset_q][fway_q]) begin
                    state_d = StFlWb;
                end else if (state_q == StFlScan || mem_req_ready_i) begin
                    dclr = (state_q == StFlWb);
                    if (fl_last) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StFlScan;
                        if (fway_q == WB'(WAYS - 1)) begin
                            fway_d = '0;
                            fset_d = fset_q + IDX'(1);
                        end else begin
                            fway_d = fway_q + WB'(1);
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign flush_busy_o = (state_q == StFlScan) || (state_q == StFlWb);
    assign flush_done_o = done_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            write_q <= 1'b0;
            way_q   <= '0;
            rdata_q <= '0;
            fset_q  <= '0;
            fway_q  <= '0;
            done_q  <= 1'b0;
            for (int s = 0; s < int'(SETS); s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            write_q <= write_d;
            way_q   <= way_d;
            rdata_q <= rdata_d;
            fset_q  <= fset_d;
            fway_q  <= fway_d;
            done_q  <= done_d;
            if (we_line) begin
                valid_q[cur_idx][ww] <= 1'b1;
                dirty_q[cur_idx][ww] <= wdirty;
            end
            if (dclr) dirty_q[fset_q][fway_q] <= 1'b0;
            if (plru_we) plru_q[cur_idx] <= plru_touch(plru_q[cur_idx], ww);
        end
    end

    always_ff @(posedge clk_i) begin
        if (we_line) begin
            data_q[cur_idx][ww] <= wline;
            tag_q[cur_idx][ww]  <= cur_tag;
        end
    end

endmodule

// File: tb/tb_dcache_nway.sv
// Directed self-checking bench for dcache_nway at default geometry (512 sets, 32 B lines, 2 ways).
module tb_dcache_nway;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid, req_ready, req_write;
    logic [31:0]  address, write_data;
    logic [3:0]   write_mask;
    logic         resp_valid;
    logic [31:0]  read_data;
    logic         flush_req, flush_busy, flush_done;
    logic         mem_req_valid, mem_req_ready, mem_req_write;
    logic [31:0]  mem_address;
    logic [255:0] mem_write_data;
    logic         mem_resp_valid;
    logic [255:0] mem_read_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dcache_nway dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_write_i      (req_write),
        .address_i        (address),
        .write_data_i     (write_data),
        .write_mask_i     (write_mask),
        .resp_valid_o     (resp_valid),
        .read_data_o      (read_data),
        .flush_req_i      (flush_req),
        .flush_busy_o     (flush_busy),
        .flush_done_o     (flush_done),
        .mem_req_valid_o  (mem_req_valid),
        .mem_req_ready_i  (mem_req_ready),
        .mem_req_write_o  (mem_req_write),
        .mem_address_o    (mem_address),
        .mem_write_data_o (mem_write_data),
        .mem_resp_valid_i (mem_resp_valid),
        .mem_read_data_i  (mem_read_data)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_req(input logic wr, input logic [31:0] addr, input logic [31:0] d,
                           input logic [3:0] m);
        int n = 0;
        req_valid  = 1'b1;
        req_write  = wr;
        address    = addr;
        write_data = d;
        write_mask = m;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        chk("req_ready", req_ready, 1);
        tick();
        req_valid  = 1'b0;
        req_write  = 1'b0;
        write_data = '0;
        write_mask = '0;
    endtask

    // Call right after cpu_req: a hit answers in the very next cycle with no memory traffic.
    task automatic hit_check(input string tag, input logic [31:0] rd);
        chk({tag, "_resp"}, resp_valid, 1);
        chk({tag, "_rdata"}, read_data, rd);
        chk({tag, "_nomem"}, mem_req_valid, 0);
        chk({tag, "_busy"}, req_ready, 0);
        tick();
        chk({tag, "_ready2"}, req_ready, 1);
    endtask

    // Waits for a memory request, checks it (and its stability over 'hold' stalled cycles),
    // then completes the handshake.
    task automatic mem_expect(input string tag, input logic wr, input logic [31:0] addr,
                              input logic [255:0] wd, input int hold);
        int n = 0;
        while (!mem_req_valid && n < 3000) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, mem_req_valid, 1);
        chk({tag, "_write"}, mem_req_write, wr);
        chk({tag, "_addr"}, mem_address, addr);
        if (wr) chk({tag, "_wdata"}, mem_write_data, wd);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_hold_valid"}, mem_req_valid, 1);
            chk({tag, "_hold_addr"}, mem_address, addr);
            chk({tag, "_hold_wdata"}, mem_write_data, wd);
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
    endtask

    task automatic mem_fill(input logic [255:0] line);
        mem_resp_valid = 1'b1;
        mem_read_data  = line;
        tick();
        mem_resp_valid = 1'b0;
        mem_read_data  = '0;
    endtask

    task automatic expect_resp(input string tag, input logic [31:0] rd);
        int n = 0;
        while (!resp_valid && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_resp"}, resp_valid, 1);
        chk({tag, "_rdata"}, read_data, rd);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [255:0] line0, line1, line2, line3, line7, exp_line;
    int n;

    initial begin
        for (int i = 0; i < 8; i++) begin
            line0[i*32 +: 32] = 32'hA000_0000 | 32'(i);
            line1[i*32 +: 32] = 32'hB000_0000 | 32'(i);
            line2[i*32 +: 32] = 32'hC000_0000 | 32'(i);
            line3[i*32 +: 32] = 32'hD000_0000 | 32'(i);
            line7[i*32 +: 32] = 32'hE000_0000 | 32'(i);
        end
        line0[63:32] = 32'hDEAD_BEEF;

        rst_n          = 1'b0;
        req_valid      = 1'b0;
        req_write      = 1'b0;
        address        = '0;
        write_data     = '0;
        write_mask     = '0;
        flush_req      = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_read_data  = '0;

        // Reset state
        tick();
        tick();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_read_data", read_data, 0);
        chk("rst_flush_busy", flush_busy, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_mem_valid", mem_req_valid, 0);
        chk("rst_mem_write", mem_req_write, 0);
        chk("rst_mem_addr", mem_address, 0);
        chk("rst_mem_wdata", mem_write_data, 0);
        rst_n = 1'b1;
        tick();

        // Cold read miss, then hit
        cpu_req(1'b0, 32'h1004, '0, '0);
        chk("miss_mreq_next_cycle", mem_req_valid, 1);
        mem_expect("fetch1000", 1'b0, 32'h1000, '0, 0);
        chk("fill_wait_not_ready", req_ready, 0);
        mem_fill(line0);
        chk("miss_resp_k1", resp_valid, 1);
        chk("miss_rdata", read_data, 32'hDEAD_BEEF);
        tick();
        chk("miss_resp_one_cycle", resp_valid, 0);
        cpu_req(1'b0, 32'h1004, '0, '0);
        hit_check("rehit1004", 32'hDEAD_BEEF);

        // Byte-masked store hit, then read back merged word
        cpu_req(1'b1, 32'h1004, 32'h0000_AB00, 4'b0010);
        hit_check("st_hit1004", 32'h0);
        cpu_req(1'b0, 32'h1004, '0, '0);
        hit_check("ld_merged1004", 32'hDEAD_ABEF);

        // Dirty eviction in set 0x080 with a stalled writeback
        cpu_req(1'b1, 32'h1000, 32'h1234_5678, 4'hF);
        hit_check("st_hit1000", 32'h0);
        cpu_req(1'b0, 32'h5000, '0, '0);
        mem_expect("fetch5000", 1'b0, 32'h5000, '0, 0);
        mem_fill(line1);
        expect_resp("ld5000", 32'hB000_0000);
        exp_line         = line0;
        exp_line[31:0]   = 32'h1234_5678;
        exp_line[63:32]  = 32'hDEAD_ABEF;
        cpu_req(1'b0, 32'h9000, '0, '0);
        mem_expect("wb1000", 1'b1, 32'h1000, exp_line, 4);
        chk("fetch_follows_wb", mem_req_valid, 1);
        mem_expect("fetch9000", 1'b0, 32'h9000, '0, 0);
        mem_fill(line2);
        expect_resp("ld9000", 32'hC000_0000);
        cpu_req(1'b0, 32'h5000, '0, '0);
        hit_check("rehit5000", 32'hB000_0000);

        // Two dirty lines (sets 3 and 7) via store misses
        cpu_req(1'b1, 32'h0060, 32'hCAFE_F00D, 4'hF);
        mem_expect("fetch0060", 1'b0, 32'h0060, '0, 0);
        mem_fill(line3);
        expect_resp("st0060", 32'h0);
        cpu_req(1'b1, 32'h00E4, 32'h0BAD_CAFE, 4'b1100);
        mem_expect("fetch00E0", 1'b0, 32'h00E0, '0, 0);
        mem_fill(line7);
        expect_resp("st00E4", 32'h0);

        // Flush-all: writebacks in set order, then done pulse
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        chk("flush_busy", flush_busy, 1);
        chk("flush_not_ready", req_ready, 0);
        exp_line        = line3;
        exp_line[31:0]  = 32'hCAFE_F00D;
        mem_expect("flwb0060", 1'b1, 32'h0060, exp_line, 0);
        exp_line        = line7;
        exp_line[63:32] = 32'h0BAD_0001;
        mem_expect("flwb00E0", 1'b1, 32'h00E0, exp_line, 0);
        n = 0;
        while (!flush_done && n < 3000) begin
            tick();
            n++;
        end
        chk("flush_done", flush_done, 1);
        chk("flush_done_busy_low", flush_busy, 0);
        tick();
        chk("flush_done_pulse", flush_done, 0);

        // Flushed line is clean: evicting it issues a fetch, not a writeback
        cpu_req(1'b0, 32'h4060, '0, '0);
        mem_expect("fetch4060", 1'b0, 32'h4060, '0, 0);
        mem_fill(line1);
        expect_resp("ld4060", 32'hB000_0000);
        cpu_req(1'b0, 32'h8060, '0, '0);
        mem_expect("evict_clean8060", 1'b0, 32'h8060, '0, 0);
        mem_fill(line2);
        expect_resp("ld8060", 32'hC000_0000);

        // Clean-cache flush: 1024 scan cycles, done on the next
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        n = 0;
        while (!flush_done && n < 3000) begin
            chk("clean_flush_nomem", mem_req_valid, 0);
            tick();
            n++;
        end
        chk("clean_flush_cycles", n, 1024);
        tick();

        // Asynchronous reset during FILL_WAIT
        cpu_req(1'b0, 32'h2000, '0, '0);
        mem_expect("fetch2000", 1'b0, 32'h2000, '0, 0);
        chk("pre_rst_not_ready", req_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_async_ready", req_ready, 1);
        chk("rst_async_mem_valid", mem_req_valid, 0);
        chk("rst_async_resp", resp_valid, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        cpu_req(1'b0, 32'h2000, '0, '0);
        chk("post_rst_miss", mem_req_valid, 1);
        mem_expect("refetch2000", 1'b0, 32'h2000, '0, 0);
        mem_fill(line0);
        expect_resp("ld2000", 32'hA000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dcache_nway.md
# dcache_nway

Parametrised N-way set-associative, write-back, write-allocate data cache with a valid/ready CPU port and a line-wide memory port with explicit handshakes. Successor to the fixed 2-way data cache. Adds configurable geometry, tree pseudo-LRU replacement, a multi-cycle refill/writeback FSM that tolerates memory latency, and a flush-all mode that writes back every dirty line. Sits between the MEM stage and the data memory / bus interface.

## Interface

Parameters:

- ADDR_WIDTH, 32, address width.
- LINE_BYTES, 32, line size; power of 2, ≥ 8.
- SETS, 512, number of sets; power of 2.
- WAYS, 2, associativity; power of 2, 2..8.

Derived values:

- OFF = log2(LINE_BYTES).
- IDX = log2(SETS).
- TAG = ADDR_WIDTH−IDX−OFF.
- LW = 8·LINE_BYTES.

Ports:

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  CPU request.
- req_ready  out  1  cache accepts a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- address  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
- write_data  in  32  store data.
- write_mask  in  4  byte enables; bit i enables write_data[8i+7:8i].
- resp_valid  out  1  one-cycle completion pulse, for loads and stores.
- read_data  out  32  load data; 0 for stores.
- flush_req  in  1  start flush-all; sampled only while req_ready=1.
- flush_busy  out  1  flush-all in progress.
- flush_done  out  1  one-cycle pulse when flush-all completes.
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_write  out  1  1 = line writeback, 0 = line fetch.
- mem_address  out  ADDR_WIDTH  line-aligned address (low OFF bits 0).
- mem_write_data  out  LW  writeback line.
- mem_resp_valid  in  1  fetched line valid, one-cycle pulse.
- mem_read_data  in  LW  fetched line.

## Operation

- Per-line state: valid, dirty, tag. Per set: WAYS−1 pLRU bits.
- FSM states: IDLE, WB, FILL_REQ, FILL_WAIT, RESP, FL_SCAN, FL_WB.
- req_ready = 1 only in IDLE.
- IDLE:
  - flush_req=1 has priority over req_valid in the same cycle; go to FL_SCAN.
  - Else, on req_valid, perform a combinational lookup against all ways.
  - At most one way may hit.
- Hit:
  - Load returns word address[OFF−1:2] of the hit line.
  - Store merges write_mask bytes and sets dirty.
  - Update pLRU to point away from the hit way; go to RESP.
- Miss, victim selection:
  - Victim = lowest-numbered invalid way; else the pLRU victim.
  - Latch address, data, mask, write flag and victim.
  - Victim dirty → WB. Otherwise → FILL_REQ.
- WB:
  - mem_req_write=1, mem_address = {victim tag, index, 0}, mem_write_data = victim line.
  - On mem_req_ready → FILL_REQ.
- FILL_REQ: mem_req_write=0 with the request line address. On mem_req_ready → FILL_WAIT.
- FILL_WAIT: on mem_resp_valid, install mem_read_data.
  - Store: merge the masked bytes; dirty=1. Load: dirty=0.
  - Set valid and tag; update pLRU; go to RESP.
- RESP: resp_valid=1 and read_data driven for one cycle; return to IDLE.
- FL_SCAN: iterate (set, way) from (0,0) to (SETS−1, WAYS−1), way fastest, one line per cycle.
  - Dirty line → FL_WB, which writes it back (same handshake as WB), clears dirty, keeps valid, then resumes at the next line.
  - After the last line: flush_done pulses for one cycle, then IDLE.
  - flush_busy = state ∈ {FL_SCAN, FL_WB}.
- Handshake rule: mem_req_valid, mem_req_write, mem_address and mem_write_data stay stable until the cycle mem_req_ready=1.
- mem_resp_valid outside FILL_WAIT is ignored.

## Timing

- Reset values:
  - All valid, dirty and pLRU bits = 0; state IDLE.
  - req_ready=1; all other outputs 0.
- Reset asserted mid-transaction aborts immediately: mem_req_valid drops in the same cycle (asynchronous), and no resp_valid is issued.
- Hit latency: request accepted in cycle 0; resp_valid in cycle 1; req_ready low in cycle 1 and high in cycle 2.
- Clean miss:
  - mem_req_valid is asserted in the cycle after acceptance.
  - If mem_resp_valid arrives in cycle k, resp_valid is asserted in cycle k+1.
- Dirty miss: the writeback handshake completes before the fetch request starts; at least 1 cycle of WB.
- Flush of a clean cache takes exactly SETS·WAYS cycles in FL_SCAN; flush_done follows in the next cycle.
- CPU requests presented while req_ready=0 are not accepted; the requester holds them.

## Test plan

Defaults: SETS=512, LINE_BYTES=32, WAYS=2.

- Cold read 0x0000_1004 → mem fetch 0x0000_1000 (write=0). Return a line with word1=0xDEADBEEF → resp_valid with read_data 0xDEADBEEF. Re-read → resp_valid 1 cycle after acceptance, no mem_req_valid.
- Store 0x0000AB00 mask 4'b0010 to 0x1004 → hit, resp_valid with read_data 0. Read 0x1004 → 0xDEADABEF.
- Store to 0x1000, then read 0x5000, then read 0x9000 (same set 0x080) → writeback to 0x1000 carrying the stored data, then fetch of 0x9000. The 0x5000 line stays resident (reread hits).
- Hold mem_req_ready=0 for 5 cycles during a dirty eviction → mem_req_valid, mem_address and mem_write_data stable all 5 cycles. Writeback completes on the ready cycle; the fetch follows.
- Two dirty lines in sets 3 and 7, then flush_req → two writebacks in order set 3 then set 7, flush_done pulse, flush_busy then low. Evicting those lines afterwards issues no writeback.
- Drive reset low during FILL_WAIT → mem_req_valid=0 and req_ready=1 immediately. After release, a read of the same address misses.
